i8080_bus_cycle_ctrl: RTL and testbench

Machine-cycle sequencer sitting directly upstream of the data bus buffer in the i8080 core. It accepts a bus-cycle request from the core's control unit, steps through T1/T2/TW/T3 (plus a halt state), and generates the buffer's control inputs (sync, status, out_wenable, out_enable, in_enable). It also generates the external strobes (DBIN, WR_n) and wait/ready handling. It guarantees the buffer's tri-state drivers never contend.

---
 rtl/i8080_bus_cycle_ctrl.sv | 156 +++++++++++++++
 tb/tb_i8080_bus_cycle_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/i8080_bus_cycle_ctrl.sv
// i8080 machine-cycle sequencer: steps T1/T2/TW/T3/HALT for one bus request and
// decodes the data bus buffer controls and external strobes from the state register.
module i8080_bus_cycle_ctrl #(
  parameter int unsigned XLEN = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req,
  input  logic [3:0]      cycle_type,
  input  logic            ready,
  input  logic            int_req,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] status,
  output logic            sync,
  output logic            dbin,
  output logic            wr_n,
  output logic            out_wenable,
  output logic            out_enable,
  output logic            in_enable,
  output logic            addr_en,
  output logic            wait_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T1   = 3'd1;
  localparam logic [2:0] S_T2   = 3'd2;
  localparam logic [2:0] S_TW   = 3'd3;
  localparam logic [2:0] S_T3   = 3'd4;
  localparam logic [2:0] S_HALT = 3'd5;

  localparam logic [3:0] CT_FETCH       = 4'd0;
  localparam logic [3:0] CT_MEM_READ    = 4'd1;
  localparam logic [3:0] CT_MEM_WRITE   = 4'd2;
  localparam logic [3:0] CT_STACK_READ  = 4'd3;
  localparam logic [3:0] CT_STACK_WRITE = 4'd4;
  localparam logic [3:0] CT_IN          = 4'd5;
  localparam logic [3:0] CT_OUT         = 4'd6;
  localparam logic [3:0] CT_INTA        = 4'd7;
  localparam logic [3:0] CT_HALT        = 4'd8;
  localparam logic [3:0] CT_INTA_HALT   = 4'd9;

  function automatic logic [7:0] status_code(input logic [3:0] t);
    logic [7:0] s;
    case (t)
      CT_FETCH:       s = 8'hA2;
      CT_MEM_READ:    s = 8'h82;
      CT_MEM_WRITE:   s = 8'h00;
      CT_STACK_READ:  s = 8'h86;
      CT_STACK_WRITE: s = 8'h04;
      CT_IN:          s = 8'h42;
      CT_OUT:         s = 8'h10;
      CT_INTA:        s = 8'h23;
      CT_HALT:        s = 8'h8A;
      CT_INTA_HALT:   s = 8'h2B;
      default:        s = 8'h82;
    endcase
    return s;
  endfunction

  // Reserved codes 10-15 are folded to MEM_READ at capture so the decode only sees defined kinds.
  function automatic logic [3:0] norm_type(input logic [3:0] t);
    return (t > CT_INTA_HALT) ? CT_MEM_READ : t;
  endfunction

  logic [2:0] state, state_nxt;
  logic [3:0] ctype;
  logic       is_write, is_halt, is_read;
  logic       accept;

  always_comb begin
    is_write = (ctype == CT_MEM_WRITE) || (ctype == CT_STACK_WRITE) || (ctype == CT_OUT);
    is_halt  = (ctype == CT_HALT);
    is_read  = !is_write && !is_halt;
  end

  always_comb begin
    busy        = (state != S_IDLE);
    done        = 1'b0;
    sync        = 1'b0;
    dbin        = 1'b0;
    wr_n        = 1'b1;
    out_wenable = 1'b0;
    out_enable  = 1'b0;
    in_enable   = 1'b0;
    addr_en     = 1'b0;
    wait_o      = 1'b0;
    case (state)
      S_T1: begin
        sync    = 1'b1;
        addr_en = 1'b1;
      end
      S_T2: begin
        addr_en     = 1'b1;
        dbin        = is_read;
        out_wenable = is_write;
        out_enable  = is_write;
      end
      S_TW: begin
        addr_en    = 1'b1;
        wait_o     = 1'b1;
        dbin       = is_read;
        out_enable = is_write;
      end
      S_T3: begin
        addr_en    = 1'b1;
        done       = 1'b1;
        dbin       = is_read;
        in_enable  = is_read;
        out_enable = is_write;
        wr_n       = !is_write;
      end
      S_HALT: begin
        wait_o = 1'b1;
        done   = int_req;
      end
      default: ;
    endcase
  end

  assign accept = req && ((state == S_IDLE) || done);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = accept ? S_T1 : S_IDLE;
      S_T1:   state_nxt = S_T2;
      S_T2: begin
        if (is_halt)    state_nxt = S_HALT;
        else if (ready) state_nxt = S_T3;
        else            state_nxt = S_TW;
      end
      S_TW:   state_nxt = ready ? S_T3 : S_TW;
      S_T3:   state_nxt = accept ? S_T1 : S_IDLE;
      S_HALT: begin
        if (int_req) state_nxt = accept ? S_T1 : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      ctype  <= CT_MEM_READ;
      status <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        ctype  <= norm_type(cycle_type);
        status <= XLEN'(status_code(cycle_type));
      end
    end
  end

endmodule

// File: tb/tb_i8080_bus_cycle_ctrl.sv
// Scoreboard bench for i8080_bus_cycle_ctrl: stimulus queues hand-derived per-clock
// output vectors, a negedge monitor pops and compares them and checks bus invariants.
module tb_i8080_bus_cycle_ctrl;

  logic       clk, rst, req, ready, int_req;
  logic [3:0] cycle_type;
  logic       busy, done, sync, dbin, wr_n, out_wenable, out_enable, in_enable, addr_en, wait_o;
  logic [7:0] status;

  i8080_bus_cycle_ctrl #(.XLEN(8)) dut (
    .clk(clk), .rst(rst), .req(req), .cycle_type(cycle_type), .ready(ready),
    .int_req(int_req), .busy(busy), .done(done), .status(status), .sync(sync),
    .dbin(dbin), .wr_n(wr_n), .out_wenable(out_wenable), .out_enable(out_enable),
    .in_enable(in_enable), .addr_en(addr_en), .wait_o(wait_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic busy, sync, dbin, wr_n, owe, oe, ie, aen, wt, done;
    logic [7:0] status;
  } vec_t;

  localparam int P_IDLE = 0, P_T1 = 1, P_T2 = 2, P_TW = 3, P_T3 = 4, P_HALT = 5;
  localparam int C_R = 0, C_W = 1, C_H = 2;

  vec_t       sbq[$];
  int         total = 0;
  int         bad = 0;
  int         vec_idx = 0;
  logic [7:0] stat_tab [16];
  int         cls_tab [16];
  logic [7:0] last_status;
  bit         in_t3;
  logic       prev_done;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t vec(input int ph, input int cls, input logic [7:0] st, input logic d);
    vec_t v;
    v = '0;
    v.wr_n = 1'b1;
    v.status = st;
    case (ph)
      P_T1: begin v.busy = 1; v.sync = 1; v.aen = 1; end
      P_T2: begin
        v.busy = 1; v.aen = 1;
        if (cls == C_R) v.dbin = 1;
        if (cls == C_W) begin v.owe = 1; v.oe = 1; end
      end
      P_TW: begin
        v.busy = 1; v.aen = 1; v.wt = 1;
        if (cls == C_R) v.dbin = 1;
        if (cls == C_W) v.oe = 1;
      end
      P_T3: begin
        v.busy = 1; v.aen = 1; v.done = 1;
        if (cls == C_R) begin v.dbin = 1; v.ie = 1; end
        if (cls == C_W) begin v.oe = 1; v.wr_n = 0; end
      end
      P_HALT: begin v.busy = 1; v.wt = 1; v.done = d; end
      default: ;
    endcase
    return v;
  endfunction

  function automatic vec_t cur_vec();
    vec_t v;
    v = {busy, sync, dbin, wr_n, out_wenable, out_enable, in_enable, addr_en, wait_o, done, status};
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      if (sbq.size() > 0) begin
        vec_t e;
        e = sbq.pop_front();
        check($sformatf("vec#%0d", vec_idx), 32'(cur_vec()), 32'(e));
        vec_idx++;
      end else if (busy) begin
        check("unexpected_busy", 32'(busy), 32'd0);
      end
      check("invariants", {28'd0, in_enable && out_enable, sync && (in_enable || out_enable),
                           !wr_n && dbin, done && prev_done}, 32'd0);
      prev_done = done;
    end
  end

  task automatic do_cycle(input logic [3:0] t, input int waits, input bit keep);
    logic [7:0] st;
    int cls;
    st  = stat_tab[t];
    cls = cls_tab[t];
    if (!in_t3) sbq.push_back(vec(P_IDLE, C_R, last_status, 1'b0));
    sbq.push_back(vec(P_T1, cls, st, 1'b0));
    sbq.push_back(vec(P_T2, cls, st, 1'b0));
    for (int i = 0; i < waits; i++) sbq.push_back(vec(P_TW, cls, st, 1'b0));
    sbq.push_back(vec(P_T3, cls, st, 1'b0));
    req = 1'b1; cycle_type = t; ready = (waits == 0);
    @(posedge clk); #1;
    req = keep; cycle_type = 4'h8;
    @(posedge clk); #1;
    for (int i = 0; i < waits; i++) begin
      @(posedge clk); #1;
      ready = (i == waits - 1);
    end
    @(posedge clk); #1;
    last_status = st;
    in_t3 = keep;
    if (!keep) begin @(posedge clk); #1; end
  endtask

  task automatic do_halt();
    if (!in_t3) sbq.push_back(vec(P_IDLE, C_R, last_status, 1'b0));
    sbq.push_back(vec(P_T1, C_H, 8'h8A, 1'b0));
    sbq.push_back(vec(P_T2, C_H, 8'h8A, 1'b0));
    for (int i = 0; i < 10; i++) sbq.push_back(vec(P_HALT, C_H, 8'h8A, 1'b0));
    sbq.push_back(vec(P_HALT, C_H, 8'h8A, 1'b1));
    req = 1'b1; cycle_type = 4'd8; ready = 1'b0;
    @(posedge clk); #1;
    req = 1'b0; cycle_type = 4'd1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    repeat (9) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    int_req = 1'b1;
    @(posedge clk); #1;
    int_req = 1'b0;
    last_status = 8'h8A;
    in_t3 = 1'b0;
  endtask

  task automatic reset_mid_tw();
    sbq.push_back(vec(P_IDLE, C_R, last_status, 1'b0));
    sbq.push_back(vec(P_T1, C_W, 8'h10, 1'b0));
    sbq.push_back(vec(P_T2, C_W, 8'h10, 1'b0));
    sbq.push_back(vec(P_TW, C_W, 8'h10, 1'b0));
    req = 1'b1; cycle_type = 4'd6; ready = 1'b0;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_async", 32'(cur_vec()), 32'(vec(P_IDLE, C_R, 8'h00, 1'b0)));
    check("rst_queue", 32'(sbq.size()), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; ready = 1'b1;
    last_status = 8'h00;
    in_t3 = 1'b0;
  endtask

  initial begin
    stat_tab = '{8'hA2, 8'h82, 8'h00, 8'h86, 8'h04, 8'h42, 8'h10, 8'h23,
                 8'h8A, 8'h2B, 8'h82, 8'h82, 8'h82, 8'h82, 8'h82, 8'h82};
    cls_tab  = '{C_R, C_R, C_W, C_R, C_W, C_R, C_W, C_R,
                 C_H, C_R, C_R, C_R, C_R, C_R, C_R, C_R};
    last_status = 8'h00;
    in_t3 = 1'b0;
    prev_done = 1'b0;
    rst = 1'b1; req = 1'b0; cycle_type = 4'd0; ready = 1'b1; int_req = 1'b0;
    #1;
    check("reset_state", 32'(cur_vec()), 32'(vec(P_IDLE, C_R, 8'h00, 1'b0)));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("idle_after_release", 32'(cur_vec()), 32'(vec(P_IDLE, C_R, 8'h00, 1'b0)));

    do_cycle(4'd1, 0, 1'b0);
    do_cycle(4'd2, 2, 1'b0);
    do_cycle(4'd0, 0, 1'b1);
    do_cycle(4'd6, 0, 1'b0);
    do_cycle(4'd3, 1, 1'b0);
    do_cycle(4'd4, 0, 1'b0);
    do_cycle(4'd5, 0, 1'b0);
    do_cycle(4'd7, 1, 1'b0);
    do_cycle(4'd9, 0, 1'b0);
    do_halt();
    do_cycle(4'd12, 0, 1'b0);
    do_cycle(4'd15, 3, 1'b0);
    reset_mid_tw();
    do_cycle(4'd1, 0, 1'b0);

    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(posedge clk);
    #1;
    check("drain", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
